mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares the single memory bus port between the instruction fetch unit and the data (load/store) unit. It latches one outstanding request per requester, issues one request at a time to the downstream memory port, waits for its response, and routes the returned data back to the issuing requester. It sits between the core's fetch/memory-access stages and the memory controller, using the `memreq`/`memresp` structs and `MEMREQ_*` modes from `def.sv`.

## Interface
- No parameters.
- `clk`  in  1  clock; all logic on posedge.
- `rstn`  in  1  reset, synchronous, active-low.
- `f_request_enable`  in  1  fetch request pulse, one cycle.
- `f_request`  in  memreq  fetch request payload, valid with pulse.
- `f_response_enable`  out  1  fetch response pulse, one cycle.
- `f_response`  out  memresp  fetch response payload, held until next fetch response.
- `d_request_enable`  in  1  data request pulse, one cycle.
- `d_request`  in  memreq  data request payload (read or write).
- `d_response_enable`  out  1  data response pulse, one cycle.
- `d_response`  out  memresp  data response payload, held.
- `m_request_enable`  out  1  downstream request pulse, one cycle.
- `m_request`  out  memreq  downstream payload, held until next issue.
- `m_response_enable`  in  1  downstream response pulse.
- `m_response`  in  memresp  downstream response payload.
- `busy`  out  1  high whenever state != IDLE or any request pending.

## Operation
- Per-port pending latch: `f_pend`/`f_buf`, `d_pend`/`d_buf`. Request pulse on a port with `pend`=0 and not in flight: payload copied, `pend`<=1.
- Request pulse on a port already pending or in flight: ignored (payload not captured, no effect on state).
- FSM states: IDLE, WAIT.
  - IDLE: if any `pend`, select winner, drive `m_request`<=winner buf, `m_request_enable`<=1, `owner`<=winner, clear winner `pend`, go WAIT. Else stay.
  - WAIT: on `m_response_enable`: copy `m_response` to owner's response reg, pulse owner's `*_response_enable`, go IDLE. Otherwise stay.
- Selection without macro: fixed priority, data over fetch.
- `m_response_enable` in IDLE: dropped, no output pulse.
- Request pulse captured in same cycle as IDLE evaluation is not visible to that evaluation (pending is registered).
- Port may pulse a new request in the same cycle its response pulse is high; it is captured.
- Reset: state IDLE, both `pend`=0, `owner`=fetch, all `*_enable` outputs 0, all payload outputs 0, `busy`=0, round-robin pointer = data preferred.

## Timing
- Request pulse sampled at edge k -> `pend` high after k -> `m_request_enable` high for cycle after edge k+1.
- `m_response_enable` sampled at edge j in WAIT -> owner response enable high for cycle after edge j; state IDLE after j.
- Next downstream issue no earlier than edge j+1.
- Minimum request-to-response latency: 2 cycles plus memory latency.
- All enable outputs are single-cycle pulses; never high two consecutive cycles for the same transaction.
- Back-to-back: with both pending, second issue occurs edge after first response.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: when both pending in IDLE, grant goes to the port not granted last; pointer updates on every grant. Single pending port always granted. After reset, data wins first tie.
- Undefined: fixed priority data > fetch; fetch can wait indefinitely under continuous data traffic.

## Test plan
- Single fetch read addr 0x0000_1000, memory responds data 0xDEAD_BEEF 3 cycles after issue -> `m_request.addr`=0x1000 mode READ, `f_response.data`=0xDEAD_BEEF with one-cycle `f_response_enable`, no `d_response_enable`.
- Fetch 0x100 and data write 0x200 pulsed same cycle -> data issued first (both configs after reset), fetch issued edge after data response; responses route to correct ports.
- Round-robin on: repeated simultaneous pairs x4 -> grants alternate D,F,D,F,D,F,D,F; off -> D always issued before F each pair.
- Duplicate fetch pulse (addr 0x300) while fetch 0x100 in flight -> only 0x100 issued; 0x300 never appears on `m_request`.
- Spurious `m_response_enable` in IDLE -> no response pulses, state IDLE, `busy`=0.
- Reset asserted in WAIT, late `m_response_enable` after release -> dropped; all outputs 0, pending cleared, next fetch request served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the fetch and data requesters, one transaction at a time.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin on ties; default is fixed data-over-fetch priority.
// Payload layout: memreq = {mode[1:0], addr[31:0], wdata[31:0]}, memresp = data[31:0].
module mem_arbiter (
  input  logic        clk,
  input  logic        rstn,
  input  logic        f_request_enable,
  input  logic [65:0] f_request,
  output logic        f_response_enable,
  output logic [31:0] f_response,
  input  logic        d_request_enable,
  input  logic [65:0] d_request,
  output logic        d_response_enable,
  output logic [31:0] d_response,
  output logic        m_request_enable,
  output logic [65:0] m_request,
  input  logic        m_response_enable,
  input  logic [31:0] m_response,
  output logic        busy
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state, state_nx;
  logic        f_pend, d_pend;
  logic [65:0] f_buf, d_buf;
  logic        owner_d;
  logic        issue, grant_d, complete;
  logic        f_inflight, d_inflight;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic        rr_pref_d;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    grant_d  = 1'b0;
    complete = 1'b0;
    case (state)
      IDLE: begin
        if (f_pend || d_pend) begin
          issue = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          grant_d = d_pend && (!f_pend || rr_pref_d);
`else
          grant_d = d_pend;
`endif
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (m_response_enable) begin
          complete = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    f_inflight = (state == WAIT) && !owner_d;
    d_inflight = (state == WAIT) && owner_d;
    busy       = (state != IDLE) || f_pend || d_pend;
  end

  // A port's pend and its issue are mutually exclusive per cycle, so capture and clear never collide.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      f_pend            <= 1'b0;
      d_pend            <= 1'b0;
      f_buf             <= '0;
      d_buf             <= '0;
      owner_d           <= 1'b0;
      m_request_enable  <= 1'b0;
      m_request         <= '0;
      f_response_enable <= 1'b0;
      f_response        <= '0;
      d_response_enable <= 1'b0;
      d_response        <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_pref_d         <= 1'b1;
`endif
    end else begin
      m_request_enable  <= 1'b0;
      f_response_enable <= 1'b0;
      d_response_enable <= 1'b0;

      if (issue) begin
        m_request_enable <= 1'b1;
        m_request        <= grant_d ? d_buf : f_buf;
        owner_d          <= grant_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        rr_pref_d        <= !grant_d;
`endif
        if (grant_d) d_pend <= 1'b0;
        else         f_pend <= 1'b0;
      end

      if (complete) begin
        if (owner_d) begin
          d_response        <= m_response;
          d_response_enable <= 1'b1;
        end else begin
          f_response        <= m_response;
          f_response_enable <= 1'b1;
        end
      end

      if (f_request_enable && !f_pend && !f_inflight) begin
        f_pend <= 1'b1;
        f_buf  <= f_request;
      end
      if (d_request_enable && !d_pend && !d_inflight) begin
        d_pend <= 1'b1;
        d_buf  <= d_request;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic checked every cycle against a transaction-level reference model.
module tb_mem_arbiter;

  localparam logic [1:0] MEMREQ_READ  = 2'd0;
  localparam logic [1:0] MEMREQ_WRITE = 2'd1;

  logic        clk = 1'b0;
  logic        rstn;
  logic        f_request_enable, d_request_enable, m_response_enable;
  logic [65:0] f_request, d_request;
  logic [31:0] m_response;
  logic        f_response_enable, d_response_enable, m_request_enable, busy;
  logic [31:0] f_response, d_response;
  logic [65:0] m_request;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rstn(rstn),
    .f_request_enable(f_request_enable), .f_request(f_request),
    .f_response_enable(f_response_enable), .f_response(f_response),
    .d_request_enable(d_request_enable), .d_request(d_request),
    .d_response_enable(d_response_enable), .d_response(d_response),
    .m_request_enable(m_request_enable), .m_request(m_request),
    .m_response_enable(m_response_enable), .m_response(m_response),
    .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [65:0] mk_req(input logic [1:0] mode, input logic [31:0] addr,
                                          input logic [31:0] wdata);
    return {mode, addr, wdata};
  endfunction

  // Reference model: each port holds at most one outstanding transaction (accepted, response
  // not yet delivered); waiting ones are issued one at a time when the bus has no owner.
  bit          mf_out, md_out, mf_wait, md_wait, m_last_d;
  logic [65:0] mf_buf, md_buf;
  int          m_owner;
  logic        e_mreq_en, e_fre, e_dre;
  logic [65:0] e_mreq;
  logic [31:0] e_fresp, e_dresp;

  task automatic model_edge();
    int  pre_owner;
    bit  pre_fout, pre_dout, pick_d;
    e_mreq_en = 1'b0;
    e_fre     = 1'b0;
    e_dre     = 1'b0;
    if (!rstn) begin
      mf_out = 0; md_out = 0; mf_wait = 0; md_wait = 0; m_last_d = 0;
      mf_buf = '0; md_buf = '0; m_owner = -1;
      e_mreq = '0; e_fresp = '0; e_dresp = '0;
      return;
    end
    pre_owner = m_owner;
    pre_fout  = mf_out;
    pre_dout  = md_out;
    if (pre_owner < 0 && (mf_wait || md_wait)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      pick_d = md_wait && (!mf_wait || !m_last_d);
`else
      pick_d = md_wait;
`endif
      m_last_d  = pick_d;
      e_mreq_en = 1'b1;
      e_mreq    = pick_d ? md_buf : mf_buf;
      m_owner   = pick_d ? 1 : 0;
      if (pick_d) md_wait = 0;
      else        mf_wait = 0;
    end
    if (pre_owner >= 0 && m_response_enable) begin
      if (pre_owner == 1) begin e_dre = 1'b1; e_dresp = m_response; md_out = 0; end
      else                begin e_fre = 1'b1; e_fresp = m_response; mf_out = 0; end
      m_owner = -1;
    end
    if (f_request_enable && !pre_fout) begin mf_out = 1; mf_wait = 1; mf_buf = f_request; end
    if (d_request_enable && !pre_dout) begin md_out = 1; md_wait = 1; md_buf = d_request; end
  endtask

  // Bench-side memory: answers each issue after a latency drawn from [mem_lat_lo, mem_lat_hi].
  bit          auto_mem = 1'b1;
  bit          mem_busy = 1'b0;
  int          mem_cnt, mem_lat_lo = 1, mem_lat_hi = 1;
  logic [31:0] mem_data_q[$];
  logic [65:0] issued[$];
  int          f_cnt, d_cnt;

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("m_request_enable", m_request_enable, e_mreq_en);
    chk("m_request", m_request, e_mreq);
    chk("f_response_enable", f_response_enable, e_fre);
    chk("f_response", f_response, e_fresp);
    chk("d_response_enable", d_response_enable, e_dre);
    chk("d_response", d_response, e_dresp);
    chk("busy", busy, (m_owner >= 0) || mf_wait || md_wait);
    if (f_response_enable) f_cnt++;
    if (d_response_enable) d_cnt++;
    f_request_enable  = 1'b0;
    d_request_enable  = 1'b0;
    m_response_enable = 1'b0;
    if (!rstn) mem_busy = 1'b0;
    else if (auto_mem) begin
      if (m_request_enable) begin
        issued.push_back(m_request);
        mem_busy = 1'b1;
        mem_cnt  = int'($urandom_range(mem_lat_hi, mem_lat_lo));
      end
      if (mem_busy) begin
        if (mem_cnt <= 1) begin
          m_response_enable = 1'b1;
          m_response = (mem_data_q.size() > 0) ? mem_data_q.pop_front() : $urandom();
          mem_busy = 1'b0;
        end else mem_cnt--;
      end
    end
  endtask

  task automatic run_until_idle(input string nm);
    int n = 0;
    do begin step(); n++; end
    while ((busy || mem_busy || m_response_enable) && n < 80);
    checks++;
    if (n >= 80) begin
      errors++;
      $display("FAIL %s_timeout: got busy after %0d cycles expected idle", nm, n);
    end
  endtask

  typedef struct {
    bit          fe;
    logic [31:0] fa;
    bit          de;
    logic [31:0] da;
    logic [1:0]  dmode;
    int          lat;
    logic [31:0] rd0, rd1;
    int          exp_n;
    logic [31:0] exp_a0, exp_a1;
    logic [1:0]  exp_mode0;
    int          exp_fcnt, exp_dcnt;
    logic [31:0] exp_fdata, exp_ddata;
  } vec_t;

  function automatic vec_t mkv(bit fe, logic [31:0] fa, bit de, logic [31:0] da, logic [1:0] dm,
                               int lat, logic [31:0] rd0, logic [31:0] rd1, int n,
                               logic [31:0] a0, logic [31:0] a1, logic [1:0] m0,
                               int fc, int dc, logic [31:0] fd, logic [31:0] dd);
    vec_t v;
    v.fe = fe; v.fa = fa; v.de = de; v.da = da; v.dmode = dm; v.lat = lat;
    v.rd0 = rd0; v.rd1 = rd1; v.exp_n = n; v.exp_a0 = a0; v.exp_a1 = a1; v.exp_mode0 = m0;
    v.exp_fcnt = fc; v.exp_dcnt = dc; v.exp_fdata = fd; v.exp_ddata = dd;
    return v;
  endfunction

  task automatic start_req(input bit fe, input logic [31:0] fa, input bit de,
                           input logic [31:0] da, input logic [1:0] dm);
    f_request_enable = fe;
    f_request        = mk_req(MEMREQ_READ, fa, 32'h0);
    d_request_enable = de;
    d_request        = mk_req(dm, da, da ^ 32'h5A5A_0000);
  endtask

  function automatic logic [31:0] iss_addr(input int i);
    return (issued.size() > i) ? issued[i][63:32] : 32'hxxxx_xxxx;
  endfunction

  vec_t vecs[5];

  initial begin
    rstn = 1'b0;
    f_request_enable = 1'b0; d_request_enable = 1'b0; m_response_enable = 1'b0;
    f_request = '0; d_request = '0; m_response = '0;

    vecs[0] = mkv(1, 32'h0000_1000, 0, 32'h0, MEMREQ_READ, 3, 32'hDEAD_BEEF, 32'h0, 1,
                  32'h0000_1000, 32'hx, MEMREQ_READ, 1, 0, 32'hDEAD_BEEF, 32'h0);
    vecs[1] = mkv(1, 32'h100, 1, 32'h200, MEMREQ_WRITE, 2, 32'h1111_1111, 32'h2222_2222, 2,
                  32'h200, 32'h100, MEMREQ_WRITE, 1, 1, 32'h2222_2222, 32'h1111_1111);
    vecs[2] = mkv(0, 32'h0, 1, 32'h400, MEMREQ_READ, 1, 32'h3333_3333, 32'h0, 1,
                  32'h400, 32'hx, MEMREQ_READ, 0, 1, 32'h2222_2222, 32'h3333_3333);
    vecs[3] = mkv(1, 32'h500, 0, 32'h0, MEMREQ_READ, 1, 32'h4444_4444, 32'h0, 1,
                  32'h500, 32'hx, MEMREQ_READ, 1, 0, 32'h4444_4444, 32'h3333_3333);
    vecs[4] = mkv(1, 32'h700, 1, 32'h800, MEMREQ_READ, 2, 32'h5555_5555, 32'h6666_6666, 2,
                  32'h800, 32'h700, MEMREQ_READ, 1, 1, 32'h6666_6666, 32'h5555_5555);

    repeat (3) step();
    rstn = 1'b1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_m_request_enable", m_request_enable, 1'b0);
    chk("reset_m_request", m_request, 66'h0);
    chk("reset_f_response", f_response, 32'h0);
    chk("reset_d_response", d_response, 32'h0);

    foreach (vecs[i]) begin
      issued.delete(); mem_data_q.delete();
      f_cnt = 0; d_cnt = 0;
      mem_data_q.push_back(vecs[i].rd0); mem_data_q.push_back(vecs[i].rd1);
      mem_lat_lo = vecs[i].lat; mem_lat_hi = vecs[i].lat;
      start_req(vecs[i].fe, vecs[i].fa, vecs[i].de, vecs[i].da, vecs[i].dmode);
      run_until_idle("vec");
      chk("vec_issue_count", issued.size(), vecs[i].exp_n);
      chk("vec_issue0_addr", iss_addr(0), vecs[i].exp_a0);
      chk("vec_issue0_mode", (issued.size() > 0) ? issued[0][65:64] : 2'bxx, vecs[i].exp_mode0);
      if (vecs[i].exp_n > 1) chk("vec_issue1_addr", iss_addr(1), vecs[i].exp_a1);
      chk("vec_f_pulses", f_cnt, vecs[i].exp_fcnt);
      chk("vec_d_pulses", d_cnt, vecs[i].exp_dcnt);
      chk("vec_f_data", f_response, vecs[i].exp_fdata);
      chk("vec_d_data", d_response, vecs[i].exp_ddata);
    end

    // Four simultaneous pairs: D then F each pair in either configuration.
    mem_lat_lo = 1; mem_lat_hi = 3;
    for (int p = 0; p < 4; p++) begin
      issued.delete();
      start_req(1, 32'h1000 + 32'(p * 16), 1, 32'h2000 + 32'(p * 16), MEMREQ_READ);
      run_until_idle("pair");
      chk("pair_first_is_data", iss_addr(0), 32'h2000 + 32'(p * 16));
      chk("pair_second_is_fetch", iss_addr(1), 32'h1000 + 32'(p * 16));
    end

    // A tie right after a data-only grant separates the two arbitration policies.
    start_req(0, 32'h0, 1, 32'hB00, MEMREQ_READ);
    run_until_idle("donly");
    issued.delete();
    start_req(1, 32'hC00, 1, 32'hD00, MEMREQ_WRITE);
    run_until_idle("tie");
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("tie_after_data_grant", iss_addr(0), 32'hC00);
`else
    chk("tie_after_data_grant", iss_addr(0), 32'hD00);
`endif

    // Duplicate fetch pulses while pending and while in flight are dropped.
    issued.delete();
    mem_lat_lo = 4; mem_lat_hi = 4;
    start_req(1, 32'h100, 0, 32'h0, MEMREQ_READ);
    step();
    start_req(1, 32'h300, 0, 32'h0, MEMREQ_READ);
    step();
    start_req(1, 32'h304, 0, 32'h0, MEMREQ_READ);
    run_until_idle("dup");
    chk("dup_issue_count", issued.size(), 1);
    chk("dup_issue_addr", iss_addr(0), 32'h100);

    // Spurious memory response while idle.
    f_cnt = 0; d_cnt = 0;
    m_response_enable = 1'b1; m_response = 32'hFEED_F00D;
    step();
    step();
    chk("spurious_f_pulses", f_cnt, 0);
    chk("spurious_d_pulses", d_cnt, 0);
    chk("spurious_busy", busy, 1'b0);

    // Reset while waiting on memory; the late response after release is dropped.
    issued.delete();
    mem_lat_lo = 6; mem_lat_hi = 6;
    start_req(1, 32'h900, 0, 32'h0, MEMREQ_READ);
    repeat (3) step();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    auto_mem = 1'b0;
    f_cnt = 0;
    m_response_enable = 1'b1; m_response = 32'hBAD0_0000;
    step();
    step();
    chk("rstwait_f_pulses", f_cnt, 0);
    chk("rstwait_busy", busy, 1'b0);
    chk("rstwait_m_request", m_request, 66'h0);
    chk("rstwait_f_response", f_response, 32'h0);
    auto_mem = 1'b1;
    issued.delete(); mem_data_q.delete();
    mem_data_q.push_back(32'h1234_5678);
    mem_lat_lo = 2; mem_lat_hi = 2;
    start_req(1, 32'hA00, 0, 32'h0, MEMREQ_READ);
    run_until_idle("after_rst");
    chk("after_rst_addr", iss_addr(0), 32'hA00);
    chk("after_rst_data", f_response, 32'h1234_5678);

    // Randomized traffic against the model.
    mem_data_q.delete();
    mem_lat_lo = 1; mem_lat_hi = 4;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(2, 0) == 0) begin
        f_request_enable = 1'b1;
        f_request = mk_req(MEMREQ_READ, $urandom(), 32'h0);
      end
      if ($urandom_range(2, 0) == 0) begin
        d_request_enable = 1'b1;
        d_request = mk_req(2'($urandom_range(1, 0)), $urandom(), $urandom());
      end
      if (!mem_busy && !m_response_enable && $urandom_range(9, 0) == 0) begin
        m_response_enable = 1'b1;
        m_response = $urandom();
      end
      step();
    end
    run_until_idle("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
